// File: rtl/register_file_mp_pkg.sv
// Shared definitions for the multi-port register file: sequencer state
// encoding and the packed-port slice helper used by the read mux generate loop.
package register_file_mp_pkg;

  // Clear sequencer states: CLEAR sweeps the array to zero, RUN accepts writes.
  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_e;

  // Lowest bit index of port 'port' inside a packed bus of 'width'-bit fields.
  function automatic int unsigned rf_lsb(input int unsigned port, input int unsigned width);
    return port * width;
  endfunction

endpackage

// File: rtl/register_file_mp_if.sv
// Bus bundle between decode/ALU (master) and the register file (slave):
// two active-low write ports, packed read selects, packed read data and Ready.
interface register_file_mp_if #(
  parameter int DataWidth  = 8,
  parameter int SelectSize = 3,
  parameter int ReadPorts  = 2
);

  logic                              REG_WE0;
  logic [SelectSize-1:0]             REG_Dst0;
  logic [DataWidth-1:0]              DIn0;
  logic                              REG_WE1;
  logic [SelectSize-1:0]             REG_Dst1;
  logic [DataWidth-1:0]              DIn1;
  logic [ReadPorts*SelectSize-1:0]   REG_Src;
  logic [ReadPorts*DataWidth-1:0]    SRC;
  logic                              Ready;

  modport master (
    output REG_WE0, REG_Dst0, DIn0,
    output REG_WE1, REG_Dst1, DIn1,
    output REG_Src,
    input  SRC, Ready
  );

  modport slave (
    input  REG_WE0, REG_Dst0, DIn0,
    input  REG_WE1, REG_Dst1, DIn1,
    input  REG_Src,
    output SRC, Ready
  );

endinterface

// File: rtl/register_file_mp_clear_seq.sv
// Clear-on-reset sequencer: after Reset falls it walks ClrAddr over every
// register (one per cycle) and then parks in RUN with Ready high.
module register_file_mp_clear_seq
  import register_file_mp_pkg::*;
#(
  parameter int SelectSize = 3
) (
  input  logic                  Clk,
  input  logic                  Reset,
  output logic                  Ready,
  output logic                  ClrWe,
  output logic [SelectSize-1:0] ClrAddr
);

  localparam logic [SelectSize-1:0] LastAddr = {SelectSize{1'b1}};

  rf_state_e             state_q, state_d;
  logic [SelectSize-1:0] clr_cnt_q, clr_cnt_d;
  logic                  ready_q, ready_d;

  // State register: synchronous reset restarts the sweep from address zero.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= RF_CLEAR;
      clr_cnt_q <= {SelectSize{1'b0}};
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      ready_q   <= ready_d;
    end
  end

  // Next state: advance the sweep; the counter holds at the last address instead of wrapping.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    ready_d   = ready_q;
    case (state_q)
      RF_CLEAR: begin
        if (clr_cnt_q == LastAddr) begin
          state_d = RF_RUN;
          ready_d = 1'b1;
        end else begin
          clr_cnt_d = clr_cnt_q + SelectSize'(1);
          ready_d   = 1'b0;
        end
      end
      RF_RUN: begin
        ready_d = 1'b1;
      end
      default: begin
        state_d   = RF_CLEAR;
        clr_cnt_d = {SelectSize{1'b0}};
        ready_d   = 1'b0;
      end
    endcase
  end

  // Outputs: clear strobe only while sweeping and not held in reset.
  always_comb begin
    ClrAddr = clr_cnt_q;
    Ready   = ready_q;
    if ((state_q == RF_CLEAR) && !Reset) begin
      ClrWe = 1'b1;
    end else begin
      ClrWe = 1'b0;
    end
  end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file: flop array with a sequenced clear, two write ports
// (port 1 wins on a collision), optional hardwired-zero R0 and optional
// same-cycle write-to-read bypass on every read port.
module register_file_mp
  import register_file_mp_pkg::*;
#(
  parameter int DataWidth  = 8,
  parameter int SelectSize = 3,
  parameter int ReadPorts  = 2,
  parameter int ZeroReg    = 0,
  parameter int Bypass     = 1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  register_file_mp_if.slave     bus
);

  localparam int RegisterCnt = 1 << SelectSize;

  logic [DataWidth-1:0]  mem_q [RegisterCnt];
  logic [DataWidth-1:0]  mem_d [RegisterCnt];
  logic                  ready_s;
  logic                  clr_we_s;
  logic [SelectSize-1:0] clr_addr_s;
  logic                  wr0_s;
  logic                  wr1_s;

  register_file_mp_clear_seq #(
    .SelectSize (SelectSize)
  ) u_clear_seq (
    .Clk     (Clk),
    .Reset   (Reset),
    .Ready   (ready_s),
    .ClrWe   (clr_we_s),
    .ClrAddr (clr_addr_s)
  );

  assign bus.Ready = ready_s;

  // A write commits only in RUN, outside reset, and never to R0 when R0 is hardwired.
  assign wr0_s = ready_s && !Reset && !bus.REG_WE0 &&
                 !((ZeroReg != 0) && (bus.REG_Dst0 == {SelectSize{1'b0}}));
  assign wr1_s = ready_s && !Reset && !bus.REG_WE1 &&
                 !((ZeroReg != 0) && (bus.REG_Dst1 == {SelectSize{1'b0}}));

  // Next array contents: clear sweep first, then port 1 over port 0, else hold.
  always_comb begin
    for (int r = 0; r < RegisterCnt; r++) begin
      if (clr_we_s && (clr_addr_s == SelectSize'(r))) begin
        mem_d[r] = {DataWidth{1'b0}};
      end else if (wr1_s && (bus.REG_Dst1 == SelectSize'(r))) begin
        mem_d[r] = bus.DIn1;
      end else if (wr0_s && (bus.REG_Dst0 == SelectSize'(r))) begin
        mem_d[r] = bus.DIn0;
      end else begin
        mem_d[r] = mem_q[r];
      end
    end
  end

  // Flop array; no reset of its own because the clear sweep zeroes it.
  always_ff @(posedge Clk) begin
    mem_q <= mem_d;
  end

  // One read port: forced zero while clearing, hardwired R0, bypass (port 1 first), else array.
  function automatic logic [DataWidth-1:0] read_mux(
    input logic                  run,
    input logic [SelectSize-1:0] sel,
    input logic                  we0_n,
    input logic [SelectSize-1:0] dst0,
    input logic [DataWidth-1:0]  din0,
    input logic                  we1_n,
    input logic [SelectSize-1:0] dst1,
    input logic [DataWidth-1:0]  din1,
    input logic [DataWidth-1:0]  arr_val
  );
    logic [DataWidth-1:0] r;
    if (!run) begin
      r = {DataWidth{1'b0}};
    end else if ((ZeroReg != 0) && (sel == {SelectSize{1'b0}})) begin
      r = {DataWidth{1'b0}};
    end else if ((Bypass != 0) && !we1_n && (dst1 == sel)) begin
      r = din1;
    end else if ((Bypass != 0) && !we0_n && (dst0 == sel)) begin
      r = din0;
    end else begin
      r = arr_val;
    end
    return r;
  endfunction

  for (genvar k = 0; k < ReadPorts; k++) begin : g_rd
    localparam int SelLsb  = rf_lsb(k, SelectSize);
    localparam int DataLsb = rf_lsb(k, DataWidth);
    logic [SelectSize-1:0] sel_s;

    assign sel_s = bus.REG_Src[SelLsb +: SelectSize];
    assign bus.SRC[DataLsb +: DataWidth] = read_mux(ready_s, sel_s,
                                                    bus.REG_WE0, bus.REG_Dst0, bus.DIn0,
                                                    bus.REG_WE1, bus.REG_Dst1, bus.DIn1,
                                                    mem_q[sel_s]);
  end

endmodule
